mem_unit: RTL and testbench

Memory stage of the 16-bit WISC pipeline; sits between the execute stage and writeback. It consumes the execute stage's outputs: load/store flags, ALU result used as address, destination register, and future-return flag. It runs data-memory accesses over a request/ready handshake, stalls upstream while an access is outstanding, and registers results for writeback. It closes the return path by asserting `ret_wb` with the popped `PC_stack_pointer`, which the execute stage consumes to update the PC.

---
 rtl/mem_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - WISC memory stage: data-memory handshake, stall, writeback and return path (optional store buffer: MEM_STORE_BUFFER_EN)
module mem_unit #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_to_reg_in,
    input  logic              reg_to_mem_in,
    input  logic              ret_future_in,
    input  logic [3:0]        reg_rd_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ready,
    output logic              wb_valid,
    output logic              wb_mem_to_reg,
    output logic [3:0]        wb_reg_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              ret_wb,
    output logic [DATA_W-1:0] PC_stack_pointer,
    output logic              mem_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_COMPLETE = 2'd2;

    localparam logic [1:0] K_LW  = 2'd0;
    localparam logic [1:0] K_SW  = 2'd1;
    localparam logic [1:0] K_RET = 2'd2;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [1:0]        state;
    logic [1:0]        op_kind;
    logic [3:0]        wait_cnt;
    logic [3:0]        lat_rd;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;

    logic is_lw, is_sw, is_ret, is_none, is_mem;
    logic busy, accept;
    logic [1:0] new_kind;

`ifdef MEM_STORE_BUFFER_EN
    // One buffered store; shares lat_addr/lat_data with ACCESS since the two never overlap.
    logic buf_valid;
`endif

    // Decode the op kind; any combination of two or more flags is an illegal no-op.
    always_comb begin
        is_lw    = mem_to_reg_in  & ~reg_to_mem_in & ~ret_future_in;
        is_sw    = ~mem_to_reg_in &  reg_to_mem_in & ~ret_future_in;
        is_ret   = ~mem_to_reg_in & ~reg_to_mem_in &  ret_future_in;
        is_none  = ~mem_to_reg_in & ~reg_to_mem_in & ~ret_future_in;
        is_mem   = is_lw | is_sw | is_ret;
        new_kind = is_sw ? K_SW : (is_ret ? K_RET : K_LW);
    end

    // Stall and memory request derive from state (plus buffer occupancy when enabled).
    always_comb begin
`ifdef MEM_STORE_BUFFER_EN
        stall = (state == S_ACCESS) || (buf_valid && in_valid && is_mem);
        busy  = (state == S_ACCESS) || buf_valid;
`else
        stall = (state == S_ACCESS);
        busy  = (state == S_ACCESS);
`endif
        accept   = in_valid && !stall;
        dm_req   = busy;
        dm_we    = busy && (op_kind == K_SW);
        dm_addr  = lat_addr;
        dm_wdata = lat_data;
    end

    // FSM, latched request, wait counter and registered writeback/return outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            op_kind          <= K_LW;
            wait_cnt         <= 4'd0;
            lat_rd           <= 4'd0;
            lat_addr         <= '0;
            lat_data         <= '0;
            wb_valid         <= 1'b0;
            wb_mem_to_reg    <= 1'b0;
            wb_reg_rd        <= 4'd0;
            wb_data          <= '0;
            ret_wb           <= 1'b0;
            PC_stack_pointer <= '0;
            mem_err          <= 1'b0;
`ifdef MEM_STORE_BUFFER_EN
            buf_valid        <= 1'b0;
`endif
        end else begin
            wb_valid      <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            ret_wb        <= 1'b0;

            if (state == S_COMPLETE) begin
                state <= S_IDLE;
            end

            if (busy) begin
                if (dm_ready) begin
`ifdef MEM_STORE_BUFFER_EN
                    buf_valid <= 1'b0;
`endif
                    if (state == S_ACCESS) begin
                        state <= S_COMPLETE;
                        if (op_kind == K_LW) begin
                            wb_valid      <= 1'b1;
                            wb_mem_to_reg <= 1'b1;
                            wb_data       <= dm_rdata;
                            wb_reg_rd     <= lat_rd;
                        end else if (op_kind == K_RET) begin
                            ret_wb           <= 1'b1;
                            PC_stack_pointer <= dm_rdata;
                        end
                    end
                end else begin
                    // Request stays held after a timeout; the error just sticks.
                    if (wait_cnt != MAX_W) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                    if (wait_cnt + 4'd1 == MAX_W) begin
                        mem_err <= 1'b1;
                    end
                end
            end

            if (accept) begin
                if (is_mem) begin
                    op_kind  <= new_kind;
                    lat_addr <= alu_result;
                    lat_data <= wr_data;
                    lat_rd   <= reg_rd_in;
                    wait_cnt <= 4'd0;
`ifdef MEM_STORE_BUFFER_EN
                    if (is_sw) begin
                        buf_valid <= 1'b1;
                    end else begin
                        state <= S_ACCESS;
                    end
`else
                    state <= S_ACCESS;
`endif
                end else if (is_none) begin
                    wb_valid  <= 1'b1;
                    wb_data   <= alu_result;
                    wb_reg_rd <= reg_rd_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        mem_to_reg_in;
    logic        reg_to_mem_in;
    logic        ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result;
    logic [15:0] wr_data;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        wb_valid;
    logic        wb_mem_to_reg;
    logic [3:0]  wb_reg_rd;
    logic [15:0] wb_data;
    logic        ret_wb;
    logic [15:0] PC_stack_pointer;
    logic        mem_err;

    int checks;
    int errors;

    mem_unit #(.DATA_W(16), .MAX_WAIT(15)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .mem_to_reg_in    (mem_to_reg_in),
        .reg_to_mem_in    (reg_to_mem_in),
        .ret_future_in    (ret_future_in),
        .reg_rd_in        (reg_rd_in),
        .alu_result       (alu_result),
        .wr_data          (wr_data),
        .stall            (stall),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_ready         (dm_ready),
        .wb_valid         (wb_valid),
        .wb_mem_to_reg    (wb_mem_to_reg),
        .wb_reg_rd        (wb_reg_rd),
        .wb_data          (wb_data),
        .ret_wb           (ret_wb),
        .PC_stack_pointer (PC_stack_pointer),
        .mem_err          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic lw, input logic sw, input logic rt,
                         input logic [3:0] rd, input logic [15:0] a, input logic [15:0] d);
        in_valid      = v;
        mem_to_reg_in = lw;
        reg_to_mem_in = sw;
        ret_future_in = rt;
        reg_rd_in     = rd;
        alu_result    = a;
        wr_data       = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  32'(stall), 0);
        check({tag, "_dm_req"}, 32'(dm_req), 0);
        check({tag, "_dm_we"},  32'(dm_we), 0);
        check({tag, "_addr"},   32'(dm_addr), 0);
        check({tag, "_wdata"},  32'(dm_wdata), 0);
        check({tag, "_wbv"},    32'(wb_valid), 0);
        check({tag, "_wbm"},    32'(wb_mem_to_reg), 0);
        check({tag, "_wbrd"},   32'(wb_reg_rd), 0);
        check({tag, "_wbd"},    32'(wb_data), 0);
        check({tag, "_ret"},    32'(ret_wb), 0);
        check({tag, "_pc"},     32'(PC_stack_pointer), 0);
        check({tag, "_err"},    32'(mem_err), 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        dm_ready = 1'b0;
        dm_rdata = 16'h0;
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Non-memory op: one-cycle latency.
        @(negedge clk);
        check("alu_stall_in", 32'(stall), 0);
        drive(1, 0, 0, 0, 4'd3, 16'h1234, 16'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        check("alu_wbv", 32'(wb_valid), 1);
        check("alu_wbd", 32'(wb_data), 32'h1234);
        check("alu_rd", 32'(wb_reg_rd), 3);
        check("alu_m2r", 32'(wb_mem_to_reg), 0);
        check("alu_stall", 32'(stall), 0);
        // Stray dm_ready while idle must be ignored.
        dm_ready = 1'b1;
        dm_rdata = 16'hDEAD;
        @(negedge clk);
        dm_ready = 1'b0;
        check("idle_wbv", 32'(wb_valid), 0);
        check("idle_req", 32'(dm_req), 0);
        check("idle_ret", 32'(ret_wb), 0);

        // LW 0x0040, ready in third ACCESS cycle.
        drive(1, 1, 0, 0, 4'd5, 16'h0040, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
            check($sformatf("lw_req%0d", i), 32'(dm_req), 1);
            check($sformatf("lw_stall%0d", i), 32'(stall), 1);
            check($sformatf("lw_addr%0d", i), 32'(dm_addr), 32'h0040);
            check($sformatf("lw_we%0d", i), 32'(dm_we), 0);
            if (i == 2) begin
                dm_ready = 1'b1;
                dm_rdata = 16'hBEEF;
            end
        end
        @(negedge clk);
        dm_ready = 1'b0;
        check("lw_req_done", 32'(dm_req), 0);
        check("lw_stall_done", 32'(stall), 0);
        check("lw_wbv", 32'(wb_valid), 1);
        check("lw_wbd", 32'(wb_data), 32'hBEEF);
        check("lw_m2r", 32'(wb_mem_to_reg), 1);
        check("lw_rd", 32'(wb_reg_rd), 5);
        @(negedge clk);
        check("lw_wbv_pulse", 32'(wb_valid), 0);

        // ret from 0xFFFE.
        drive(1, 0, 0, 1, 4'd7, 16'hFFFE, 16'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        check("ret_addr", 32'(dm_addr), 32'hFFFE);
        check("ret_req", 32'(dm_req), 1);
        check("ret_we", 32'(dm_we), 0);
        dm_ready = 1'b1;
        dm_rdata = 16'h0123;
        @(negedge clk);
        dm_ready = 1'b0;
        check("ret_pulse", 32'(ret_wb), 1);
        check("ret_pc", 32'(PC_stack_pointer), 32'h0123);
        check("ret_wbv", 32'(wb_valid), 0);
        @(negedge clk);
        check("ret_pulse_end", 32'(ret_wb), 0);
        check("ret_pc_hold", 32'(PC_stack_pointer), 32'h0123);

        // Illegal flag combination is a no-op.
        drive(1, 1, 1, 0, 4'd4, 16'h0050, 16'h1111);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        check("ill_wbv", 32'(wb_valid), 0);
        check("ill_req", 32'(dm_req), 0);
        check("ill_stall", 32'(stall), 0);

        // SW 0x10 <- 0x5A5A, followed by an ALU op.
        drive(1, 0, 1, 0, 4'd1, 16'h0010, 16'h5A5A);
        @(negedge clk);
        drive(1, 0, 0, 0, 4'd2, 16'h7777, 16'h0);
        check("sw_req", 32'(dm_req), 1);
        check("sw_we", 32'(dm_we), 1);
        check("sw_addr", 32'(dm_addr), 32'h0010);
        check("sw_wdata", 32'(dm_wdata), 32'h5A5A);
        check("sw_wbv", 32'(wb_valid), 0);
`ifdef MEM_STORE_BUFFER_EN
        check("sw_alu_nostall", 32'(stall), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        check("sw_alu_wbv", 32'(wb_valid), 1);
        check("sw_alu_wbd", 32'(wb_data), 32'h7777);
        check("sw_drain_req", 32'(dm_req), 1);
        dm_ready = 1'b1;
        @(negedge clk);
        dm_ready = 1'b0;
        check("sw_drain_done", 32'(dm_req), 0);
`else
        check("sw_alu_stall", 32'(stall), 1);
        @(negedge clk);
        check("sw_alu_stall2", 32'(stall), 1);
        check("sw_alu_wbv_held", 32'(wb_valid), 0);
        dm_ready = 1'b1;
        @(negedge clk);
        dm_ready = 1'b0;
        check("sw_cmp_stall", 32'(stall), 0);
        check("sw_cmp_wbv", 32'(wb_valid), 0);
        check("sw_cmp_req", 32'(dm_req), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        check("sw_alu_wbv", 32'(wb_valid), 1);
        check("sw_alu_wbd", 32'(wb_data), 32'h7777);
        check("sw_alu_rd", 32'(wb_reg_rd), 2);
`endif

        // Timeout: dm_ready held low, mem_err after 15 waiting cycles.
        @(negedge clk);
        check("to_err_before", 32'(mem_err), 0);
        drive(1, 1, 0, 0, 4'd6, 16'h0022, 16'h0);
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
            if (j == 15) check("to_err_14", 32'(mem_err), 0);
            if (j == 16) begin
                check("to_err_15", 32'(mem_err), 1);
                check("to_req_15", 32'(dm_req), 1);
            end
            if (j == 17) begin
                check("to_err_sticky", 32'(mem_err), 1);
                check("to_req_16", 32'(dm_req), 1);
                check("to_stall_16", 32'(stall), 1);
            end
        end

        // Asynchronous reset mid-ACCESS.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        @(negedge clk);
        rst_n    = 1'b1;
        dm_ready = 1'b1;
        dm_rdata = 16'hAAAA;
        @(negedge clk);
        dm_ready = 1'b0;
        check("arst_no_wb", 32'(wb_valid), 0);
        check("arst_no_ret", 32'(ret_wb), 0);
        check("arst_wbd", 32'(wb_data), 0);
        check("arst_req", 32'(dm_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
